// File: rtl/line_mem_pkg.sv
// Shared types and constants for the cache-line memory responder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package line_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ACK
  } state_e;

  // Byte offset inside a 32-byte line; these address bits never select a line.
  localparam int LINE_OFFSET_W = 5;
  localparam int LINE_W_DEF    = 256;
  // Latency counter width; covers the legal LATENCY range 1..255.
  localparam int LAT_W         = 8;

  // Line index width for a given depth (at least one bit).
  function automatic int idx_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/line_mem_array.sv
// Single-port DEPTH x LINE_W line store with write enable and registered read.
// Latency: read data appears on the cycle after re_i; writes commit on the enabled edge.
// Backpressure: none; the caller never issues read and write on the same edge.
module line_mem_array
  import line_mem_pkg::*;
#(
  parameter int LINE_W = LINE_W_DEF,
  parameter int DEPTH  = 512,
  parameter int IDX_W  = idx_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              we_i,
  input  logic [LINE_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic              rclr_i,
  output logic [LINE_W-1:0] rdata_o
);

  logic [LINE_W-1:0] mem [DEPTH];

  // Storage is deliberately left out of reset so it maps onto plain RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem[idx_i] <= wdata_i;
    end
  end

  // Read register: clears on reset or on a cleared read, otherwise holds the last read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_o <= '0;
    end else if (re_i) begin
      rdata_o <= rclr_i ? '0 : mem[idx_i];
    end
  end

endmodule

// File: rtl/line_mem_responder.sv
// Memory-side line responder: one request at a time, fixed LATENCY, one-cycle ack/err pulse.
// Latency: ack_o high LATENCY cycles after the cycle enable_i is sampled in IDLE.
// Backpressure: new requests are only sampled in IDLE; optional counters via LINE_MEM_RESP_STATS_EN.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LINE_W-1:0] data_i,
  input  logic              enable_i,
  input  logic              write_i,
  output logic              ack_o,
  output logic [LINE_W-1:0] data_o,
  output logic              err_o
`ifdef LINE_MEM_RESP_STATS_EN
  ,
  output logic [15:0]       rd_count_o,
  output logic [15:0]       wr_count_o
`endif
);

  localparam int              IDX_W  = idx_width(DEPTH);
  localparam logic [LAT_W-1:0] LAT_M1 = LAT_W'(LATENCY - 1);

  state_e             state;
  logic [LAT_W-1:0]   cnt;
  logic               wr_q;
  logic               oor_q;
  logic [IDX_W-1:0]   idx_q;
  logic [LINE_W-1:0]  data_q;

  logic               oor_in;
  logic [IDX_W-1:0]   idx_in;
  logic               unused_offset;

  logic               go_ack;
  logic               cur_wr;
  logic               cur_oor;
  logic [IDX_W-1:0]   mem_idx;
  logic               mem_re;
  logic               mem_we;

  assign oor_in        = |addr_i[ADDR_W-1:LINE_OFFSET_W+IDX_W];
  assign idx_in        = addr_i[LINE_OFFSET_W+IDX_W-1:LINE_OFFSET_W];
  assign unused_offset = ^addr_i[LINE_OFFSET_W-1:0];

  // Steer the single array port: live request fields in IDLE, captured fields otherwise.
  always_comb begin
    go_ack  = 1'b0;
    cur_wr  = wr_q;
    cur_oor = oor_q;
    mem_idx = idx_q;
    if (state == IDLE) begin
      cur_wr  = write_i;
      cur_oor = oor_in;
      mem_idx = idx_in;
      go_ack  = enable_i && (LATENCY == 1);
    end else if (state == BUSY) begin
      go_ack  = (cnt <= LAT_W'(1));
    end
  end

  // Read (or zero for out-of-range) is launched on the edge entering ACK so data_o lines up with ack_o.
  assign mem_re = go_ack && (!cur_wr || cur_oor);
  // Write commits on the ACK edge; a reset on that same edge aborts it.
  assign mem_we = (state == ACK) && wr_q && !oor_q && !rst_i;

  // Request FSM with latency counter and registered ack/err pulses.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      ack_o  <= 1'b0;
      err_o  <= 1'b0;
      wr_q   <= 1'b0;
      oor_q  <= 1'b0;
      idx_q  <= '0;
      data_q <= '0;
    end else begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i) begin
            wr_q   <= write_i;
            oor_q  <= oor_in;
            idx_q  <= idx_in;
            data_q <= data_i;
            cnt    <= LAT_M1;
            if (LATENCY == 1) begin
              state <= ACK;
              ack_o <= 1'b1;
              err_o <= oor_in;
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          cnt <= cnt - LAT_W'(1);
          if (cnt <= LAT_W'(1)) begin
            state <= ACK;
            ack_o <= 1'b1;
            err_o <= oor_q;
          end
        end
        ACK: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  line_mem_array #(
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .idx_i   (mem_idx),
    .we_i    (mem_we),
    .wdata_i (data_q),
    .re_i    (mem_re),
    .rclr_i  (cur_oor),
    .rdata_o (data_o)
  );

`ifdef LINE_MEM_RESP_STATS_EN
  // Saturating counts of in-range completions, taken on the ACK cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
    end else if ((state == ACK) && !oor_q) begin
      if (wr_q) begin
        if (wr_count_o != 16'hFFFF) wr_count_o <= wr_count_o + 16'd1;
      end else begin
        if (rd_count_o != 16'hFFFF) rd_count_o <= rd_count_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench: request table on a LATENCY=10 instance, plus hand sequences for
// reset mid-transaction and back-to-back behaviour on a LATENCY=1 instance.
// Optional counters are checked when LINE_MEM_RESP_STATS_EN is defined.
module tb_line_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst10, en10, wr10, ack10, err10;
  logic [31:0]  addr10;
  logic [255:0] din10, dout10;

  logic         rst1, en1, wr1, ack1, err1;
  logic [31:0]  addr1;
  logic [255:0] din1, dout1;

`ifdef LINE_MEM_RESP_STATS_EN
  logic [15:0] rdc10, wrc10, rdc1, wrc1;
`endif

  line_mem_responder #(.ADDR_W(32), .LINE_W(256), .DEPTH(512), .LATENCY(10)) u_dut (
    .clk_i(clk), .rst_i(rst10), .addr_i(addr10), .data_i(din10), .enable_i(en10),
    .write_i(wr10), .ack_o(ack10), .data_o(dout10), .err_o(err10)
`ifdef LINE_MEM_RESP_STATS_EN
    , .rd_count_o(rdc10), .wr_count_o(wrc10)
`endif
  );

  line_mem_responder #(.ADDR_W(32), .LINE_W(256), .DEPTH(512), .LATENCY(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .addr_i(addr1), .data_i(din1), .enable_i(en1),
    .write_i(wr1), .ack_o(ack1), .data_o(dout1), .err_o(err1)
`ifdef LINE_MEM_RESP_STATS_EN
    , .rd_count_o(rdc1), .wr_count_o(wrc1)
`endif
  );

  typedef struct {
    logic         w;
    logic [31:0]  a;
    logic [255:0] d;
    logic         hold;
    logic         e_err;
    logic         chk_d;
    logic [255:0] e_dat;
  } vec_t;

  vec_t tbl[16];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request on the LATENCY=10 instance. lat counts the sampling cycle as 0,
  // so an ack in cycle N+LATENCY gives lat == LATENCY.
  task automatic req10(input vec_t v, output int lat, output logic e,
                       output logic [255:0] q, output logic one);
    @(negedge clk);
    en10 = 1'b1; wr10 = v.w; addr10 = v.a; din10 = v.d;
    @(posedge clk); #1;
    // Captured values must be used; scramble the live bus.
    addr10 = 32'hFFFF_FFE0; din10 = '1; wr10 = ~v.w;
    if (!v.hold) en10 = 1'b0;
    lat = 1;
    while (ack10 !== 1'b1 && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    e = err10; q = dout10;
    en10 = 1'b0;
    @(posedge clk); #1;
    one = (ack10 === 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int           lat;
    logic         e, one, saw;
    logic [255:0] q;
    vec_t         v;
    int           exp_rd, exp_wr;

    //            w     addr           data                hold  err   chkd  exp data
    tbl[0]  = '{1'b1, 32'h0000_0000, 256'h5,            1'b1, 1'b0, 1'b0, 256'h0};
    tbl[1]  = '{1'b0, 32'h0000_0000, 256'h0,            1'b1, 1'b0, 1'b1, 256'h5};
    tbl[2]  = '{1'b1, 32'h0000_0400, 256'hDEAD_BEEF,    1'b0, 1'b0, 1'b0, 256'h0};
    tbl[3]  = '{1'b0, 32'h0000_0400, 256'h0,            1'b1, 1'b0, 1'b1, 256'hDEAD_BEEF};
    tbl[4]  = '{1'b0, 32'h0000_0410, 256'h0,            1'b0, 1'b0, 1'b1, 256'hDEAD_BEEF};
    tbl[5]  = '{1'b1, 32'h0000_0020, 256'hA5A5,         1'b1, 1'b0, 1'b0, 256'h0};
    tbl[6]  = '{1'b0, 32'h0000_0020, 256'h0,            1'b1, 1'b0, 1'b1, 256'hA5A5};
    tbl[7]  = '{1'b1, 32'h0000_0040, 256'h7,            1'b1, 1'b0, 1'b1, 256'hA5A5};
    tbl[8]  = '{1'b0, 32'h0000_4000, 256'h0,            1'b1, 1'b1, 1'b1, 256'h0};
    tbl[9]  = '{1'b1, 32'h0000_4000, {256{1'b1}},       1'b1, 1'b1, 1'b1, 256'h0};
    tbl[10] = '{1'b0, 32'h0000_0000, 256'h0,            1'b0, 1'b0, 1'b1, 256'h5};
    tbl[11] = '{1'b0, 32'h0000_0040, 256'h0,            1'b1, 1'b0, 1'b1, 256'h7};
    tbl[12] = '{1'b1, 32'hFFFF_FFE0, 256'h9,            1'b1, 1'b1, 1'b1, 256'h0};
    tbl[13] = '{1'b0, 32'h0000_0400, 256'h0,            1'b1, 1'b0, 1'b1, 256'hDEAD_BEEF};
    tbl[14] = '{1'b1, 32'h0000_0400, 256'h1234,         1'b1, 1'b0, 1'b0, 256'h0};
    tbl[15] = '{1'b0, 32'h0000_0400, 256'h0,            1'b1, 1'b0, 1'b1, 256'h1234};

    rst10 = 1'b1; en10 = 1'b0; wr10 = 1'b0; addr10 = '0; din10 = '0;
    rst1  = 1'b1; en1  = 1'b0; wr1  = 1'b0; addr1  = '0; din1  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst10 = 1'b0; rst1 = 1'b0;

    chk("rst_ack", 256'(ack10), 256'h0);
    chk("rst_err", 256'(err10), 256'h0);
    chk("rst_data", dout10, 256'h0);
    chk("rst_ack_l1", 256'(ack1), 256'h0);
`ifdef LINE_MEM_RESP_STATS_EN
    chk("rst_rd_count", 256'(rdc10), 256'h0);
    chk("rst_wr_count", 256'(wrc10), 256'h0);
`endif

    // Table-driven requests on the LATENCY=10 instance.
    exp_rd = 0; exp_wr = 0;
    for (int i = 0; i < 16; i++) begin
      req10(tbl[i], lat, e, q, one);
      chk($sformatf("v%0d_latency", i), 256'(lat), 256'd10);
      chk($sformatf("v%0d_ack_width", i), 256'(one), 256'h1);
      chk($sformatf("v%0d_err", i), 256'(e), 256'(tbl[i].e_err));
      if (tbl[i].chk_d) chk($sformatf("v%0d_data", i), q, tbl[i].e_dat);
      if (!tbl[i].e_err) begin
        if (tbl[i].w) exp_wr++;
        else          exp_rd++;
      end
    end

`ifdef LINE_MEM_RESP_STATS_EN
    chk("stats_rd_count", 256'(rdc10), 256'(exp_rd));
    chk("stats_wr_count", 256'(wrc10), 256'(exp_wr));
`endif

    // Reset four cycles into a write to line 1: no ack, no commit, outputs cleared.
    @(negedge clk);
    en10 = 1'b1; wr10 = 1'b1; addr10 = 32'h0000_0020; din10 = 256'h1;
    @(posedge clk); #1;
    en10 = 1'b0;
    saw = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (ack10 === 1'b1) saw = 1'b1;
    end
    rst10 = 1'b1;
    @(posedge clk); #1;
    rst10 = 1'b0;
    chk("midrst_ack", 256'(ack10), 256'h0);
    chk("midrst_err", 256'(err10), 256'h0);
    chk("midrst_data", dout10, 256'h0);
`ifdef LINE_MEM_RESP_STATS_EN
    chk("midrst_rd_count", 256'(rdc10), 256'h0);
`endif
    repeat (15) begin
      @(posedge clk); #1;
      if (ack10 === 1'b1) saw = 1'b1;
    end
    chk("midrst_no_ack", 256'(saw), 256'h0);
    v = '{1'b0, 32'h0000_0020, 256'h0, 1'b1, 1'b0, 1'b1, 256'hA5A5};
    req10(v, lat, e, q, one);
    chk("midrst_line1_kept", q, 256'hA5A5);
    chk("midrst_read_latency", 256'(lat), 256'd10);

    // LATENCY=1: ack in N+1; enable held through the ack edge gives a second ack in N+3.
    @(negedge clk);
    en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h0000_0040; din1 = 256'h33;
    @(posedge clk); #1;
    chk("l1_ack_n1", 256'(ack1), 256'h1);
    @(posedge clk); #1;
    chk("l1_gap_n2", 256'(ack1), 256'h0);
    @(posedge clk); #1;
    chk("l1_dup_ack_n3", 256'(ack1), 256'h1);
    en1 = 1'b0;
    @(posedge clk); #1;
    chk("l1_dup_end", 256'(ack1), 256'h0);
    @(posedge clk); #1;
    chk("l1_no_third", 256'(ack1), 256'h0);

    @(negedge clk);
    en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0000_0040;
    @(posedge clk); #1;
    en1 = 1'b0;
    chk("l1_read_ack", 256'(ack1), 256'h1);
    chk("l1_read_data", dout1, 256'h33);
    chk("l1_read_err", 256'(err1), 256'h0);
    @(posedge clk); #1;
    chk("l1_read_ack_width", 256'(ack1), 256'h0);

    @(negedge clk);
    en1 = 1'b1; wr1 = 1'b0; addr1 = 32'h0000_8000;
    @(posedge clk); #1;
    en1 = 1'b0;
    chk("l1_oor_ack", 256'(ack1), 256'h1);
    chk("l1_oor_err", 256'(err1), 256'h1);
    chk("l1_oor_data", dout1, 256'h0);
    @(posedge clk); #1;
    chk("l1_oor_err_width", 256'(err1), 256'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
